// File: rtl/ds_pkg.sv
// Constants and types shared by the delta-sigma modulator and its CIC decimator.
package ds_pkg;

  localparam int IN_BITS_DEF   = 16;
  localparam int OUT_BITS_DEF  = 9;
  localparam int FRAC_BITS_DEF = IN_BITS_DEF - OUT_BITS_DEF;

  // Two integrator sections each add DECIM_LOG2 bits of growth on top of the code width.
  function automatic int acc_width(input int out_bits, input int decim_log2);
    return out_bits + 2 * decim_log2;
  endfunction

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } cic_state_e;

endpackage

// File: rtl/cic_comb_stage.sv
// Two-section comb for a 2nd-order CIC; result is combinational on the servicing edge.
module cic_comb_stage #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         strobe,
  input  logic [W-1:0] sample,
  output logic [W-1:0] result,
  output logic         valid
);

  logic [W-1:0] z1;
  logic [W-1:0] z2;
  logic [W-1:0] d1;

  assign valid  = en && strobe;
  assign d1     = sample - z1;
  assign result = d1 - z2;

  always_ff @(posedge clk) begin
    if (reset) begin
      z1 <= '0;
      z2 <= '0;
    end else if (valid) begin
      z1 <= sample;
      z2 <= d1;
    end
  end

endmodule

// File: rtl/ds_cic_decimator.sv
// 2nd-order CIC decimator reconstructing the modulator input from its quantized code stream.
module ds_cic_decimator
  import ds_pkg::*;
#(
  parameter int IN_BITS    = IN_BITS_DEF,
  parameter int OUT_BITS   = OUT_BITS_DEF,
  parameter int DECIM_LOG2 = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [OUT_BITS-1:0] y,
  input  logic                y_valid,
  output logic [IN_BITS-1:0]  u_out,
  output logic                u_valid_out
);

  localparam int W     = acc_width(OUT_BITS, DECIM_LOG2);
  localparam int SHL   = IN_BITS - OUT_BITS;
  localparam int WIDE  = W + SHL;

  logic [W-1:0]          i1;
  logic [W-1:0]          i2;
  logic [W-1:0]          i1_next;
  logic [W-1:0]          y_ext;
  logic [DECIM_LOG2-1:0] cnt;
  logic                  strobe;
  logic                  accept;
  logic                  fire;
  logic [W-1:0]          comb_result;
  logic [WIDE-1:0]       scaled;
  logic                  load;
  cic_state_e            state;
  cic_state_e            state_next;

  assign accept  = en && y_valid;
  assign y_ext   = {{(W-OUT_BITS){1'b0}}, y};
  assign i1_next = i1 + y_ext;

  // Integrators wrap modulo 2^W on purpose; the comb differences cancel the wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      i1     <= '0;
      i2     <= '0;
      cnt    <= '0;
      strobe <= 1'b0;
    end else begin
      if (accept) begin
        i1  <= i1_next;
        i2  <= i2 + i1_next;
        cnt <= cnt + 1'b1;
      end
      if (accept && (cnt == '1)) begin
        strobe <= 1'b1;
      end else if (fire) begin
        strobe <= 1'b0;
      end
    end
  end

  cic_comb_stage #(
    .W(W)
  ) u_comb (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .strobe (strobe),
    .sample (i2),
    .result (comb_result),
    .valid  (fire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WARMUP;
    end else begin
      state <= state_next;
    end
  end

  // The first comb result after reset only primes the delay registers.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      WARMUP: begin
        if (fire) begin
          state_next = RUN;
        end
      end
      RUN: begin
        load = fire;
      end
      default: begin
        state_next = WARMUP;
      end
    endcase
  end

  assign scaled = WIDE'(comb_result) << SHL;

  always_ff @(posedge clk) begin
    if (reset) begin
      u_out       <= '0;
      u_valid_out <= 1'b0;
    end else begin
      u_valid_out <= load;
      if (load) begin
        u_out <= IN_BITS'(scaled >> (2 * DECIM_LOG2));
      end
    end
  end

endmodule

// File: tb/tb_ds_cic_decimator.sv
// Directed and random bench for ds_cic_decimator against a direct-form triangular FIR model.
module tb_ds_cic_decimator;

  localparam int IN_BITS    = 16;
  localparam int OUT_BITS   = 9;
  localparam int DECIM_LOG2 = 4;
  localparam int R          = 1 << DECIM_LOG2;
  localparam int W          = OUT_BITS + 2 * DECIM_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  logic                en;
  logic                y_valid;
  logic [OUT_BITS-1:0] y;
  logic [IN_BITS-1:0]  u_out;
  logic                u_valid_out;

  int                  vectors = 0;
  int                  miscompares = 0;

  logic [IN_BITS-1:0]  expQ[$];
  int                  hist[$];
  int                  acceptCount = 0;
  bit                  pending = 1'b0;
  logic [IN_BITS-1:0]  pendingVal = '0;
  int                  windows = 0;
  logic [IN_BITS-1:0]  lastU = '0;
  int                  constExp = -1;

  ds_cic_decimator #(
    .IN_BITS    (IN_BITS),
    .OUT_BITS   (OUT_BITS),
    .DECIM_LOG2 (DECIM_LOG2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .y           (y),
    .y_valid     (y_valid),
    .u_out       (u_out),
    .u_valid_out (u_valid_out)
  );

  always #5 clk = ~clk;

  // Triangular impulse response of length 2R-1 over the most recent accepted samples.
  function automatic logic [IN_BITS-1:0] refOutput();
    longint acc;
    longint mask;
    longint wgt;
    acc  = 0;
    mask = (longint'(1) << W) - 1;
    for (int j = 0; j < 2 * R - 1; j++) begin
      wgt = (j < R) ? longint'(j + 1) : longint'(2 * R - 1 - j);
      if (j < hist.size()) acc += wgt * longint'(hist[j]);
    end
    acc = acc & mask;
    acc = (acc << (IN_BITS - OUT_BITS)) >> (2 * DECIM_LOG2);
    return acc[IN_BITS-1:0];
  endfunction

  task automatic check(input string tag, input logic [IN_BITS-1:0] obs, input logic [IN_BITS-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input bit r, input bit e, input bit v, input logic [OUT_BITS-1:0] yy);
    if (r) begin
      hist.delete();
      expQ.delete();
      acceptCount = 0;
      pending     = 1'b0;
      windows     = 0;
      lastU       = '0;
    end else if (e) begin
      if (pending) begin
        pending = 1'b0;
        windows++;
        if (windows >= 2) expQ.push_back(pendingVal);
      end
      if (v) begin
        hist.push_front(int'(yy));
        if (hist.size() > 2 * R) void'(hist.pop_back());
        acceptCount++;
        if (acceptCount % R == 0) begin
          pending    = 1'b1;
          pendingVal = refOutput();
        end
      end
    end
  endtask

  task automatic checkOutput();
    logic expectValid;
    expectValid = (expQ.size() != 0);
    check("u_valid_out", {{(IN_BITS-1){1'b0}}, u_valid_out}, {{(IN_BITS-1){1'b0}}, expectValid});
    if (expectValid) begin
      lastU = expQ.pop_front();
      if (constExp >= 0) check("u_out_const", u_out, constExp[IN_BITS-1:0]);
    end
    check("u_out", u_out, lastU);
  endtask

  task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [OUT_BITS-1:0] yy);
    reset   = r;
    en      = e;
    y_valid = v;
    y       = yy;
    @(posedge clk);
    modelEdge(r, e, v, yy);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b0;
    y_valid = 1'b0;
    y       = '0;
    @(negedge clk);

    constExp = -1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 9'd0);

    $display("[TB] constant 256, back-to-back samples");
    constExp = 16'h8000;
    for (int i = 0; i < 90; i++) applyStimulus(1'b0, 1'b1, 1'b1, 9'd256);

    $display("[TB] alternating 100/101");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
    constExp = 12864;
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 1'b1, 1'b1, (i % 2 == 1) ? 9'd101 : 9'd100);

    $display("[TB] full-scale 511 through integrator wrap");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
    constExp = 65408;
    for (int i = 0; i < 600; i++) applyStimulus(1'b0, 1'b1, 1'b1, 9'd511);

    $display("[TB] sparse valid with enable gaps");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
    constExp = 8192;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0,
                    !((i >= 20 && i < 25) || (i >= 52 && i < 57) || (i >= 100 && i < 105)),
                    (i % 3 == 0), 9'd64);
    end

    $display("[TB] reset with strobe pending and mid-window");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
    constExp = 25600;
    for (int i = 0; i < 48; i++) applyStimulus(1'b0, 1'b1, 1'b1, 9'd200);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'd200);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 9'd200);
    applyStimulus(1'b1, 1'b1, 1'b1, 9'd200);
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, 1'b1, 1'b1, 9'd200);

    $display("[TB] random codes, valid and enable");
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 9'd0);
    constExp = -1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, ($urandom % 8) != 0, ($urandom % 4) != 0,
                    9'($urandom_range(0, 511)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
